// File: rtl/hazard_tracker.sv
// hazard_tracker: D-stage stall and D/E forwarding selects from E/M/W records.
// Optional HAZARD_MDU_EN adds a mult/div busy interlock.
module hazard_tracker #(
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       b_type,
  input  logic       cal_i,
  input  logic       cal_r,
  input  logic       load,
  input  logic       store,
  input  logic       jr,
  input  logic       jal,
  input  logic       ji,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
`ifdef HAZARD_MDU_EN
  input  logic       md_start,
  input  logic       md_div,
  input  logic       md_use,
`endif
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e
);

  logic [4:0] dec_dst;
  logic [1:0] dec_tnew;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;

  logic [4:0] e_dst_q, e_dst_d;
  logic [1:0] e_tnew_q, e_tnew_d;
  logic [4:0] e_rs_q, e_rs_d;
  logic [4:0] e_rt_q, e_rt_d;
  logic [4:0] m_dst_q, m_dst_d;
  logic [1:0] m_tnew_q, m_tnew_d;
  logic [4:0] w_dst_q, w_dst_d;
  logic [1:0] w_tnew_q, w_tnew_d;

  logic stall_haz;
  logic stall_md;

  function automatic logic [1:0] age(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic pend(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] dst,
    input logic [1:0] tnew
  );
    return (src != 5'd0) && (tuse != 2'd3)
        && (dst == src) && (tnew > tuse);
  endfunction

  function automatic logic hit(
    input logic [4:0] src,
    input logic [4:0] dst,
    input logic [1:0] tnew
  );
    return (dst != 5'd0) && (dst == src) && (tnew == 2'd0);
  endfunction

  // E-stage selects pass a null E record so only M/W can win
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] ed,
    input logic [1:0] et,
    input logic [4:0] md,
    input logic [1:0] mt,
    input logic [4:0] wd,
    input logic [1:0] wt
  );
    if (hit(src, ed, et)) return 2'd3;
    if (hit(src, md, mt)) return 2'd2;
    if (hit(src, wd, wt)) return 2'd1;
    return 2'd0;
  endfunction

  always_comb begin
    dec_dst  = 5'd0;
    dec_tnew = 2'd0;
    tuse_rs  = 2'd3;
    tuse_rt  = 2'd3;
    unique case (1'b1)
      cal_r: begin
        dec_dst  = rd;
        dec_tnew = 2'd1;
        tuse_rs  = 2'd1;
        tuse_rt  = 2'd1;
      end
      cal_i: begin
        dec_dst  = rt;
        dec_tnew = 2'd1;
        tuse_rs  = 2'd1;
      end
      load: begin
        dec_dst  = rt;
        dec_tnew = 2'd2;
        tuse_rs  = 2'd1;
      end
      store: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      b_type: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      jr, ji: tuse_rs = 2'd0;
      jal:    dec_dst = RA_REG;
      default: ;
    endcase
  end

  assign stall_haz = pend(rs, tuse_rs, e_dst_q, e_tnew_q)
                   | pend(rs, tuse_rs, m_dst_q, m_tnew_q)
                   | pend(rt, tuse_rt, e_dst_q, e_tnew_q)
                   | pend(rt, tuse_rt, m_dst_q, m_tnew_q);

  assign stall = stall_haz | stall_md;

  assign fwd_rs_d = fwd_sel(rs, e_dst_q, e_tnew_q,
                            m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
  assign fwd_rt_d = fwd_sel(rt, e_dst_q, e_tnew_q,
                            m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
  assign fwd_rs_e = fwd_sel(e_rs_q, 5'd0, 2'd0,
                            m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
  assign fwd_rt_e = fwd_sel(e_rt_q, 5'd0, 2'd0,
                            m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);

  assign e_dst_d  = stall ? 5'd0 : dec_dst;
  assign e_tnew_d = stall ? 2'd0 : dec_tnew;
  assign e_rs_d   = stall ? 5'd0 : rs;
  assign e_rt_d   = stall ? 5'd0 : rt;
  assign m_dst_d  = e_dst_q;
  assign m_tnew_d = age(e_tnew_q);
  assign w_dst_d  = m_dst_q;
  assign w_tnew_d = age(m_tnew_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_dst_q  <= 5'd0;
      e_tnew_q <= 2'd0;
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      m_dst_q  <= 5'd0;
      m_tnew_q <= 2'd0;
      w_dst_q  <= 5'd0;
      w_tnew_q <= 2'd0;
    end else begin
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
      w_tnew_q <= w_tnew_d;
    end
  end

`ifdef HAZARD_MDU_EN
  logic       e_md_q, e_md_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  assign e_md_d   = md_start & ~stall;
  assign md_cnt_d = e_md_d ? (md_div ? 4'd10 : 4'd5)
                  : (md_cnt_q != 4'd0) ? md_cnt_q - 4'd1
                  : 4'd0;
  assign stall_md = md_use & ((md_cnt_q != 4'd0) | e_md_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_md_q   <= 1'b0;
      md_cnt_q <= 4'd0;
    end else begin
      e_md_q   <= e_md_d;
      md_cnt_q <= md_cnt_d;
    end
  end
`else
  assign stall_md = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed per-cycle vectors plus reset-mid-stall
// and (with HAZARD_MDU_EN) div/mflo interlock sequences.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] cls;
  logic       b_type, cal_i, cal_r, load, store, jr, jal, ji;
  logic [4:0] rs, rt, rd;
  logic       md_start, md_div, md_use;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] NOP = 8'h00;
  localparam logic [7:0] BT  = 8'h80;
  localparam logic [7:0] CI  = 8'h40;
  localparam logic [7:0] CR  = 8'h20;
  localparam logic [7:0] LD  = 8'h10;
  localparam logic [7:0] ST  = 8'h08;
  localparam logic [7:0] JR  = 8'h04;
  localparam logic [7:0] JAL = 8'h02;

  assign {b_type, cal_i, cal_r, load, store, jr, jal, ji} = cls;

  always #5 clk = ~clk;

  hazard_tracker dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .b_type   (b_type),
    .cal_i    (cal_i),
    .cal_r    (cal_r),
    .load     (load),
    .store    (store),
    .jr       (jr),
    .jal      (jal),
    .ji       (ji),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
`ifdef HAZARD_MDU_EN
    .md_start (md_start),
    .md_div   (md_div),
    .md_use   (md_use),
`endif
    .stall    (stall),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e)
  );

  typedef struct {
    logic [7:0] cls;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       st;
    logic [1:0] fdrs;
    logic [1:0] fdrt;
    logic [1:0] fers;
    logic [1:0] fert;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [7:0] c, input int a, input int b,
                     input int d, input int s, input int p,
                     input int q, input int u, input int v);
    vec_t r;
    r.cls  = c;
    r.rs   = 5'(a);
    r.rt   = 5'(b);
    r.rd   = 5'(d);
    r.st   = 1'(s);
    r.fdrs = 2'(p);
    r.fdrt = 2'(q);
    r.fers = 2'(u);
    r.fert = 2'(v);
    tbl.push_back(r);
  endtask

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int s, input int p,
                         input int q, input int u, input int v);
    check({tag, " stall"}, int'(stall), s);
    check({tag, " fwd_rs_d"}, int'(fwd_rs_d), p);
    check({tag, " fwd_rt_d"}, int'(fwd_rt_d), q);
    check({tag, " fwd_rs_e"}, int'(fwd_rs_e), u);
    check({tag, " fwd_rt_e"}, int'(fwd_rt_e), v);
  endtask

  task automatic drive(input logic [7:0] c, input int a,
                       input int b, input int d);
    @(negedge clk);
    cls = c;
    rs  = 5'(a);
    rt  = 5'(b);
    rd  = 5'(d);
    #2;
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    cls      = NOP;
    rs       = 5'd0;
    rt       = 5'd0;
    rd       = 5'd0;
    md_start = 1'b0;
    md_div   = 1'b0;
    md_use   = 1'b0;

    // lw $1 ; addu $2,$1,$3
    row(LD,  5,  1,  0, 0, 0, 0, 0, 0);
    row(CR,  1,  3,  2, 1, 0, 0, 0, 0);
    row(CR,  1,  3,  2, 0, 0, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 1, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    // lw $1 ; beq $1,$2
    row(LD,  5,  1,  0, 0, 0, 0, 0, 0);
    row(BT,  1,  2,  0, 1, 0, 0, 0, 0);
    row(BT,  1,  2,  0, 1, 0, 0, 0, 0);
    row(BT,  1,  2,  0, 0, 1, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    // addu $1,$4,$5 ; beq $1,$0
    row(CR,  4,  5,  1, 0, 0, 0, 0, 0);
    row(BT,  1,  0,  0, 1, 0, 0, 0, 0);
    row(BT,  1,  0,  0, 0, 2, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 1, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    // jal ; jr $31
    row(JAL, 0,  0,  0, 0, 0, 0, 0, 0);
    row(JR,  31, 0,  0, 0, 3, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 2, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    // ori $0,$0,5 ; beq $0,$0
    row(CI,  0,  0,  0, 0, 0, 0, 0, 0);
    row(BT,  0,  0,  0, 0, 0, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    // lw $7 ; sw $7 : Tuse(rt)=2 meets Tnew=2, no stall
    row(LD,  0,  7,  0, 0, 0, 0, 0, 0);
    row(ST,  8,  7,  0, 0, 0, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    // jal ; jal ; jr $31 : E beats M, then M beats W
    row(JAL, 0,  0,  0, 0, 0, 0, 0, 0);
    row(JAL, 0,  0,  0, 0, 0, 0, 0, 0);
    row(JR,  31, 0,  0, 0, 3, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 2, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    // addu $10 ; nop ; addu $11,$0,$10 : rt path
    row(CR,  0,  0, 10, 0, 0, 0, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);
    row(CR,  0, 10, 11, 0, 0, 2, 0, 0);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 1);
    row(NOP, 0,  0,  0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    drive(BT, 1, 2, 0);
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cls     = NOP;
    rs      = 5'd0;
    rt      = 5'd0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cls, int'(tbl[i].rs), int'(tbl[i].rt),
            int'(tbl[i].rd));
      chk_all($sformatf("r%0d", i), int'(tbl[i].st),
              int'(tbl[i].fdrs), int'(tbl[i].fdrt),
              int'(tbl[i].fers), int'(tbl[i].fert));
    end

    // reset during a lw->beq stall clears the pending hazard
    repeat (3) drive(NOP, 0, 0, 0);
    drive(LD, 0, 1, 0);
    drive(BT, 1, 2, 0);
    reset_n = 1'b0;
    check("rst_mid stall", int'(stall), 1);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk_all("rst_after", 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk_all("rst_after2", 0, 0, 0, 0, 0);

`ifdef HAZARD_MDU_EN
    repeat (3) drive(NOP, 0, 0, 0);
    @(negedge clk);
    md_start = 1'b1;
    md_div   = 1'b1;
    md_use   = 1'b1;
    #2;
    check("div issue stall", int'(stall), 0);
    @(negedge clk);
    md_start = 1'b0;
    md_div   = 1'b0;
    md_use   = 1'b1;
    #2;
    n = 0;
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
      #2;
    end
    check("mdu div_mflo stalls", n, 10);
    md_use = 1'b0;
`else
    n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
